// File: rtl/pw_seq_lock.sv
// pw_seq_lock: multi-character password lock with retry limit, timed lockout, open window and entry timeout
module pw_seq_lock #(
    parameter int CHAR_W = 7,
    parameter int SEQ_LEN = 4,
    parameter logic [SEQ_LEN*CHAR_W-1:0] PASSWORD = {7'h12, 7'h34, 7'h56, 7'h78},
    parameter int MAX_TRIES = 3,
    parameter int OPEN_CYCLES = 1000000,
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CHAR_W-1:0]                  char_in,
    input  logic                               enter,
    output logic                               open,
    output logic                               wrong,
    output logic                               locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic [$clog2(SEQ_LEN+1)-1:0]       char_idx
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int IW = $clog2(SEQ_LEN + 1);
    localparam int DOL = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int DMAX = (DOL > TIMEOUT_CYCLES) ? DOL : TIMEOUT_CYCLES;
    localparam int CW = $clog2(DMAX) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_OPEN, S_FAIL, S_LOCK} state_t;

    state_t            state, nxt;
    logic [CHAR_W-1:0] c1, c2, ch;
    logic              e1, e2, e3, ev;
    logic [CW-1:0]     cnt, cnt_n, cnt_ld;
    logic [IW-1:0]     idx_n;
    logic [TW-1:0]     tries_n;
    logic              mismatch, mm_n, wrong_n, bad, last;
    logic [CHAR_W-1:0] pw_chr [1<<IW];

    for (genvar i = 0; i < (1 << IW); i++) begin : g_pw
        if (i < SEQ_LEN) begin : g_v
            assign pw_chr[i] = PASSWORD[(SEQ_LEN-1-i)*CHAR_W +: CHAR_W];
        end else begin : g_z
            assign pw_chr[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {c1, c2, ch} <= '0;
            {e1, e2, e3, ev} <= '0;
            state <= S_IDLE;
            cnt <= '0;
            char_idx <= '0;
            mismatch <= 1'b0;
            tries_left <= TW'(MAX_TRIES);
            wrong <= 1'b0;
            open <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            c1 <= char_in;
            c2 <= c1;
            ch <= c2;
            e1 <= enter;
            e2 <= e1;
            e3 <= e2;
            ev <= e2 & ~e3;
            state <= nxt;
            cnt <= cnt_n;
            char_idx <= idx_n;
            mismatch <= mm_n;
            tries_left <= tries_n;
            wrong <= wrong_n;
            open <= nxt == S_OPEN;
            locked_out <= state == S_LOCK;
        end
    end

    always_comb begin
        nxt = state;
        idx_n = char_idx;
        mm_n = mismatch;
        tries_n = tries_left;
        wrong_n = wrong;
        last = char_idx == IW'(SEQ_LEN - 1);
        bad = mismatch | (ch != pw_chr[char_idx]);
        case (state)
            S_IDLE, S_ENTRY: begin
                if (ev) begin
                    nxt = last ? (bad ? S_FAIL : S_OPEN) : S_ENTRY;
                    idx_n = last ? '0 : char_idx + 1'b1;
                    mm_n = !last && bad;
                    wrong_n = (state == S_IDLE) ? 1'b0 : wrong;
                end else if (state == S_ENTRY && cnt == '0) begin
                    nxt = S_IDLE;
                    idx_n = '0;
                    mm_n = 1'b0;
                end
            end
            S_OPEN: nxt = (cnt == '0) ? S_IDLE : S_OPEN;
            S_FAIL: begin
                tries_n = tries_left - 1'b1;
                wrong_n = 1'b1;
                nxt = (tries_left == TW'(1)) ? S_LOCK : S_IDLE;
            end
            S_LOCK: begin
                nxt = (cnt == '0) ? S_IDLE : S_LOCK;
                tries_n = (cnt == '0) ? TW'(MAX_TRIES) : tries_left;
            end
            default: nxt = S_IDLE;
        endcase
        tries_n = (nxt == S_OPEN) ? TW'(MAX_TRIES) : tries_n;
        cnt_ld = (nxt == S_OPEN) ? CW'(OPEN_CYCLES - 1) :
                 (nxt == S_LOCK) ? CW'(LOCKOUT_CYCLES - 1) :
                 (nxt == S_ENTRY) ? CW'(TIMEOUT_CYCLES - 1) : '0;
        cnt_n = (nxt != state || (ev && state == S_ENTRY)) ? cnt_ld :
                (cnt != '0) ? cnt - 1'b1 : cnt;
    end
endmodule

// File: tb/tb_pw_seq_lock.sv
// tb_pw_seq_lock: randomized scoreboard bench for pw_seq_lock against a sequence-level lock model
module tb_pw_seq_lock;
    localparam int OPEN_C = 8;
    localparam int LOCK_C = 16;
    localparam int TO_C = 32;
    localparam int MAXT = 3;
    localparam int K_OPEN = 1;
    localparam int K_FAIL = 2;
    localparam int K_LOCK = 3;

    typedef struct {
        int kind;
        int cyc;
        int tries;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enter = 1'b0;
    logic [6:0] char_in = '0;
    logic       open, wrong, locked_out;
    logic [1:0] tries_left;
    logic [2:0] char_idx;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   m_tries = MAXT;
    bit   m_wrong = 1'b0;
    exp_t sb[$];
    logic [6:0] pw [4];

    int   open_len, lock_len, p_tries;
    logic p_open, p_lock;

    pw_seq_lock #(
        .CHAR_W(7),
        .SEQ_LEN(4),
        .PASSWORD({7'h12, 7'h34, 7'h56, 7'h78}),
        .MAX_TRIES(MAXT),
        .OPEN_CYCLES(OPEN_C),
        .LOCKOUT_CYCLES(LOCK_C),
        .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .clk(clk),
        .reset(reset),
        .char_in(char_in),
        .enter(enter),
        .open(open),
        .wrong(wrong),
        .locked_out(locked_out),
        .tries_left(tries_left),
        .char_idx(char_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_event", kind, 0);
            return;
        end
        e = sb.pop_front();
        chk("ev_kind", kind, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        if (kind == K_OPEN) begin
            chk("open_tries", int'(tries_left), MAXT);
            chk("open_wrong", int'(wrong), 0);
        end
        if (kind == K_FAIL) begin
            chk("fail_tries", int'(tries_left), e.tries);
            chk("fail_wrong", int'(wrong), 1);
        end
    endtask

    // Monitor: every output event pops the oldest prediction; windows are timed here too.
    initial begin
        open_len = 0;
        lock_len = 0;
        p_open = 1'b0;
        p_lock = 1'b0;
        p_tries = MAXT;
        forever begin
            @(negedge clk);
            if (reset) begin
                open_len = 0;
                lock_len = 0;
                p_open = 1'b0;
                p_lock = 1'b0;
                p_tries = MAXT;
            end else begin
                if (open && !p_open) expect_ev(K_OPEN);
                if (int'(tries_left) < p_tries) expect_ev(K_FAIL);
                if (locked_out && !p_lock) expect_ev(K_LOCK);
                if (open) open_len++;
                else if (p_open) begin
                    chk("open_window", open_len, OPEN_C);
                    open_len = 0;
                end
                if (locked_out) lock_len++;
                else if (p_lock) begin
                    chk("lock_window", lock_len, LOCK_C);
                    lock_len = 0;
                end
                p_open = open;
                p_lock = locked_out;
                p_tries = int'(tries_left);
            end
        end
    end

    // Model: an attempt opens iff all four characters equal the password; otherwise it costs a try.
    task automatic predict(input bit ok);
        if (ok) begin
            sb.push_back('{K_OPEN, cyc + 4, MAXT});
            m_tries = MAXT;
            m_wrong = 1'b0;
        end else begin
            m_tries--;
            m_wrong = 1'b1;
            sb.push_back('{K_FAIL, cyc + 5, m_tries});
            if (m_tries == 0) begin
                sb.push_back('{K_LOCK, cyc + 6, 0});
                m_tries = MAXT;
            end
        end
    endtask

    task automatic press(input logic [6:0] c, input int gap, input bit fin, input bit ok);
        char_in = c;
        @(negedge clk);
        if (fin) predict(ok);
        enter = 1'b1;
        repeat (2) @(negedge clk);
        enter = 1'b0;
        repeat (3 + gap) @(negedge clk);
    endtask

    task automatic attempt(input logic [6:0] s [4]);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) ok &= (s[i] == pw[i]);
        m_wrong = 1'b0;
        for (int i = 0; i < 4; i++)
            press(s[i], (i == 3) ? 0 : int'($urandom_range(0, 8)), i == 3, ok);
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        #1;
        chk("rst_open", int'(open), 0);
        chk("rst_wrong", int'(wrong), 0);
        chk("rst_locked", int'(locked_out), 0);
        chk("rst_tries", int'(tries_left), MAXT);
        chk("rst_idx", int'(char_idx), 0);
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b0;
        m_tries = MAXT;
        m_wrong = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_release_idx", int'(char_idx), 0);
        chk("rst_release_open", int'(open), 0);
        chk("rst_sb_empty", sb.size(), 0);
    endtask

    task automatic wait_lock();
        for (int i = 0; i < 20 && !locked_out; i++) @(negedge clk);
        chk("lock_rise", int'(locked_out), 1);
    endtask

    initial begin
        logic [6:0] s [4];
        logic [6:0] bad_s [4];
        int r, k, p;
        pw = '{7'h12, 7'h34, 7'h56, 7'h78};
        bad_s = '{7'h12, 7'h34, 7'h56, 7'h79};
        repeat (3) @(negedge clk);
        chk("init_open", int'(open), 0);
        chk("init_tries", int'(tries_left), MAXT);
        reset = 1'b0;
        @(negedge clk);
        chk("init_wrong", int'(wrong), 0);
        chk("init_locked", int'(locked_out), 0);
        chk("init_idx", int'(char_idx), 0);

        attempt(pw);
        repeat (25) @(negedge clk);
        attempt(bad_s);
        repeat (25) @(negedge clk);
        attempt(pw);
        repeat (25) @(negedge clk);

        attempt(bad_s);
        repeat (25) @(negedge clk);
        attempt(bad_s);
        repeat (25) @(negedge clk);
        attempt(bad_s);
        wait_lock();
        for (int i = 0; i < 4; i++) begin
            char_in = pw[i];
            enter = 1'b1;
            @(negedge clk);
            enter = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("lock_ignores_idx", int'(char_idx), 0);
        chk("lock_still_active", int'(locked_out), 1);
        for (int i = 0; i < 40 && locked_out; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("after_lock_tries", int'(tries_left), m_tries);
        chk("after_lock_wrong", int'(wrong), int'(m_wrong));

        attempt(bad_s);
        repeat (25) @(negedge clk);
        m_wrong = 1'b0;
        press(7'h12, 0, 1'b0, 1'b0);
        press(7'h34, 0, 1'b0, 1'b0);
        chk("timeout_mid_idx", int'(char_idx), 2);
        repeat (TO_C + 8) @(negedge clk);
        chk("timeout_idx", int'(char_idx), 0);
        chk("timeout_tries", int'(tries_left), m_tries);
        chk("timeout_wrong", int'(wrong), int'(m_wrong));
        attempt(pw);
        repeat (25) @(negedge clk);

        char_in = 7'h12;
        @(negedge clk);
        enter = 1'b1;
        m_wrong = 1'b0;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_idx", int'(char_idx), 1);
        repeat (TO_C + 8) @(negedge clk);
        chk("held_timeout_idx", int'(char_idx), 0);

        attempt(pw);
        for (int i = 0; i < 20 && !open; i++) @(negedge clk);
        chk("open_before_reset", int'(open), 1);
        repeat (2) @(negedge clk);
        do_reset();

        attempt(bad_s);
        repeat (25) @(negedge clk);
        attempt(bad_s);
        repeat (25) @(negedge clk);
        attempt(bad_s);
        wait_lock();
        repeat (3) @(negedge clk);
        do_reset();

        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 3));
            s = pw;
            if (r == 1 || r == 2) begin
                p = int'($urandom_range(0, 3));
                s[p] = pw[p] ^ 7'($urandom_range(1, 127));
            end
            if (r == 3) begin
                k = int'($urandom_range(1, 3));
                m_wrong = 1'b0;
                for (int i = 0; i < k; i++) press(7'($urandom), int'($urandom_range(0, 8)), 1'b0, 1'b0);
                repeat (TO_C + 8) @(negedge clk);
                chk("abandon_idx", int'(char_idx), 0);
                chk("abandon_wrong", int'(wrong), int'(m_wrong));
                chk("abandon_tries", int'(tries_left), m_tries);
            end else begin
                attempt(s);
                repeat (25 + $urandom_range(0, 5)) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
